// File: rtl/cdb_arbiter_pkg.sv
// Shared types and default sizing for the common-data-bus arbiter.
// Imported by cdb_req_fifo, cdb_arbiter and the testbench.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ   = 5;
    localparam int CDB_NUM_PORTS = 2;
    localparam int CDB_BUF_DEPTH = 2;

    typedef enum logic [2:0] {
        CDB_REQ_ADD,
        CDB_REQ_MUL,
        CDB_REQ_DIV,
        CDB_REQ_BR,
        CDB_REQ_MEM
    } cdb_req_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rob_idx;
        logic [5:0]  pd;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
    } cdb_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-producer holding FIFO for CDB results.
// A push into a full FIFO is dropped; flush empties it at the edge.
module cdb_req_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  cdb_t                     din,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output cdb_t                     head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cdb_t          mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the pre-edge count, so a popped full FIFO still drops its push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining NUM_REQ producer FIFOs onto NUM_CDB broadcast ports.
// Optional same-cycle bypass of empty FIFOs is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = CDB_NUM_REQ,
    parameter int NUM_CDB   = CDB_NUM_PORTS,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  cdb_t [NUM_REQ-1:0]       req_i,
    output logic [NUM_REQ-1:0]       full_o,
    output cdb_t [NUM_CDB-1:0]       cdb_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     overflow_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RW-1:0]        rr_ptr;
    logic [RW-1:0]        rr_next;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   fifo_full;
    logic [NUM_REQ-1:0]   fifo_empty;
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   bypass;
    logic [NUM_REQ-1:0]   push;
    logic [NUM_REQ-1:0]   pop;
    cdb_t [NUM_REQ-1:0]   fifo_head;
    cdb_t [NUM_REQ-1:0]   src;
    logic [CW-1:0]        fifo_count [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        cdb_req_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (req_i[g]),
            .count (fifo_count[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .head  (fifo_head[g])
        );
        assign req_valid[g] = req_i[g].valid;
        assign full_o[g]    = (fifo_count[g] == CW'(BUF_DEPTH));
    end

    // A producer competes when its FIFO holds data (or, with bypass, when an empty FIFO sees a push).
    always_comb begin
        cand = '0;
        src  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CDB_BYPASS_EN
            cand[i] = !fifo_empty[i] || req_valid[i];
            src[i]  = fifo_empty[i] ? req_i[i] : fifo_head[i];
`else
            cand[i] = !fifo_empty[i];
            src[i]  = fifo_head[i];
`endif
        end
    end

    always_comb begin
        int n;
        int idx;
        cdb_o   = '0;
        grant_o = '0;
        rr_next = rr_ptr;
        n       = 0;
        idx     = 0;
        if (!flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (cand[idx] && (n < NUM_CDB)) begin
                    cdb_o[n]     = src[idx];
                    grant_o[idx] = 1'b1;
                    n            = n + 1;
                    rr_next      = (idx + 1 == NUM_REQ) ? '0 : RW'(idx + 1);
                end
            end
        end
    end

    // A bypassed result goes straight to the bus and must not also be enqueued.
    always_comb begin
        bypass = '0;
        push   = '0;
        pop    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef CDB_BYPASS_EN
            bypass[i] = grant_o[i] && fifo_empty[i];
`else
            bypass[i] = 1'b0;
`endif
            push[i] = req_valid[i] && !bypass[i];
            pop[i]  = grant_o[i] && !fifo_empty[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            rr_ptr <= rr_next;
            if (!flush && |(req_valid & fifo_full)) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule
